iob_bus_arbiter: RTL
====================

// Module: iob_bus_arbiter
// PURPOSE
//  Shares one IOb native slave port (valid/addr/wdata/wstrb -> rdata/ready) between N_MASTERS
//  requesters, e.g. the core instruction and data buses toward a single memory or DDR port.
//  One transaction is outstanding at a time.
//  Selectable round-robin or fixed-priority arbitration; the winning request is latched and
//  held on the slave until s_ready, then the response is routed back to the winner only.
// PARAMETERS
//  N_MASTERS  2   number of requesters (2..8)
//  ADDR_W     32  address width
//  DATA_W     32  data width; strobe width is DATA_W/8
//  RR         1   1 = round-robin; 0 = fixed priority, lowest index wins
// PORTS
//  clk      in   1                   clock, rising edge
//  rst      in   1                   asynchronous reset, active-high
//  m_valid  in   N_MASTERS           per-master request valid
//  m_addr   in   N_MASTERS*ADDR_W    per-master address; master i at [i*ADDR_W +: ADDR_W]
//  m_wdata  in   N_MASTERS*DATA_W    per-master write data
//  m_wstrb  in   N_MASTERS*DATA_W/8  per-master write strobe; all-zero = read
//  m_rdata  out  DATA_W              read data, broadcast to all masters; qualified by m_ready
//  m_ready  out  N_MASTERS           per-master response strobe, one cycle
//  s_valid  out  1                   slave request valid
//  s_addr   out  ADDR_W              latched address of granted master
//  s_wdata  out  DATA_W              latched write data
//  s_wstrb  out  DATA_W/8            latched strobe
//  s_rdata  in   DATA_W              slave read data
//  s_ready  in   1                   slave response strobe, one cycle
//  busy     out  1                   transaction outstanding
//  grant    out  clog2(N_MASTERS)    index of current or last granted master
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; s_valid=0; s_addr/s_wdata/s_wstrb=0; busy=0; grant=0; m_ready=0.
//   - Round-robin pointer = 0.
//  IDLE:
//   - If any m_valid, select winner W:
//     - RR=1: first set bit searching from ptr upward, wrapping modulo N_MASTERS.
//     - RR=0: lowest set index.
//   - On that edge: latch m_addr/m_wdata/m_wstrb[W] into s_*; grant<=W; s_valid<=1;
//     busy<=1; state->BUSY.
//   - Arbitration latency: 1 cycle from m_valid high to s_valid high.
//  BUSY:
//   - s_* held stable; m_valid changes on any master are ignored.
//   - On s_ready=1 (same cycle, combinational): m_ready[grant]=1 and m_rdata=s_rdata;
//     all other m_ready bits = 0.
//   - On that edge: s_valid<=0; busy<=0; ptr<=(grant+1) mod N_MASTERS; state->IDLE.
//  Throughput:
//   - Minimum 2 cycles per transaction; IDLE always lasts at least 1 cycle.
//   - New arbitration uses m_valid sampled in IDLE.
//  Master contract:
//   - Master holds m_valid and its payload until its m_ready pulse.
//   - A master that is granted and then drops m_valid still completes; its m_ready still pulses.
//  Boundary conditions:
//   - Simultaneous requests: exactly one granted per arbitration.
//   - Starvation: with RR=1, a continuously requesting master waits at most N_MASTERS-1
//     transactions.
//   - s_ready in IDLE: ignored; no m_ready pulse; no state change.
//   - N_MASTERS=1: ptr stays 0; behaves as a register slice.
//   - Pointer wrap: grant=N_MASTERS-1 -> ptr=0.
//   - rst mid-transaction: immediate return to reset values; no m_ready pulse for the
//     aborted request; the slave sees s_valid fall asynchronously.
//  m_rdata: driven from s_rdata at all times; meaningful only while some m_ready bit is 1.
// TESTING
//  1. Single read: m_valid[1]=1, addr=0x100, wstrb=0; slave s_ready after 3 cycles with
//     rdata=0xDEADBEEF -> s_valid 1 cycle after request, s_addr=0x100,
//     m_ready=2'b10 with m_rdata=0xDEADBEEF.
//  2. Simultaneous, RR=1: both masters valid continuously, slave responds in 1 cycle ->
//     grant sequence 0,1,0,1; each m_ready pulse goes to the expected master;
//     m_ready is never 2'b11.
//  3. Fixed priority, RR=0: both masters valid for 4 transactions -> all 4 granted to
//     master 0; master 1 granted only after m_valid[0] drops.
//  4. Write payload stability: master 0 writes 0x12345678 with wstrb=4'hF and changes
//     m_wdata while BUSY -> s_wdata stays 0x12345678 until s_ready.
//  5. Reset mid-transaction: assert rst while BUSY -> s_valid=0, busy=0, grant=0 immediately;
//     after release, the first request is granted by lowest index.
//  6. Spurious s_ready in IDLE -> m_ready stays 0 and state is unchanged; N_MASTERS=4 round
//     robin from ptr=3 wraps to master 0.

Source files
------------

// File: rtl/iob_bus_arbiter.sv
// N-master to single-slave IOb native bus arbiter: one transaction outstanding, round-robin
// or fixed-priority selection, request latched until s_ready, response routed to the winner.
module iob_bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR        = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [N_MASTERS-1:0]                              m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]                       m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]                       m_wdata,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]                   m_wstrb,
    output logic [DATA_W-1:0]                                 m_rdata,
    output logic [N_MASTERS-1:0]                              m_ready,
    output logic                                              s_valid,
    output logic [ADDR_W-1:0]                                 s_addr,
    output logic [DATA_W-1:0]                                 s_wdata,
    output logic [DATA_W/8-1:0]                               s_wstrb,
    input  logic [DATA_W-1:0]                                 s_rdata,
    input  logic                                              s_ready,
    output logic                                              busy,
    output logic [(N_MASTERS > 1 ? $clog2(N_MASTERS) : 1)-1:0] grant
);

    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [SW-1:0]     s_wstrb_q, s_wstrb_d;

    logic [ADDR_W-1:0] addr_arr  [N_MASTERS];
    logic [DATA_W-1:0] wdata_arr [N_MASTERS];
    logic [SW-1:0]     wstrb_arr [N_MASTERS];
    logic              valid_arr [N_MASTERS];

    logic [GW-1:0]     cand;
    logic [GW-1:0]     win_idx;
    logic              win_found;

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = m_wdata[i*DATA_W +: DATA_W];
            wstrb_arr[i] = m_wstrb[i*SW +: SW];
            valid_arr[i] = m_valid[i];
        end
    end

    // Round-robin scans upward from ptr with wrap; fixed priority always scans from index 0.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = GW'((RR != 0) ? (int'(ptr_q) + k) % N_MASTERS : k);
            if (!win_found && valid_arr[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d   = BUSY;
                    grant_d   = win_idx;
                    s_addr_d  = addr_arr[win_idx];
                    s_wdata_d = wdata_arr[win_idx];
                    s_wstrb_d = wstrb_arr[win_idx];
                end
            end
            BUSY: begin
                if (s_ready) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
        end
    end

    // Response strobe is combinational from s_ready so the winner sees it in the same cycle.
    always_comb begin
        m_ready = '0;
        if (state_q == BUSY && s_ready) begin
            m_ready[grant_q] = 1'b1;
        end
    end

    assign m_rdata = s_rdata;
    assign s_valid = (state_q == BUSY);
    assign busy    = (state_q == BUSY);
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_wstrb = s_wstrb_q;
    assign grant   = grant_q;

endmodule
